// File: rtl/timing_meas_pkg.sv
// rtl/timing_meas_pkg.sv - shared types and widths for the timing measurement block
package timing_meas_pkg;

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    ACTIVE = 2'd1,
    VBLANK = 2'd2
  } state_e;

  localparam int ERR_PIX  = 0;
  localparam int ERR_HS   = 1;
  localparam int ERR_GEOM = 2;

  localparam int CNT_W = 16;
  localparam int SUM_W = 32;

endpackage

// File: rtl/timing_meas_sat_cnt.sv
// rtl/timing_meas_sat_cnt.sv - saturating up-counter with clear and enable
// A clear together with enable restarts the count at one, so an event that
// begins a new interval is counted in the same cycle as the clear.
module sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = en_i ? W'(1) : '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/timing_meas.sv
// rtl/timing_meas.sv - per-frame geometry, pixel checksum, consistency errors and lock
module timing_meas
  import timing_meas_pkg::*;
#(
  parameter int PIXEL_WIDTH = 8,
  parameter int LOCK_FRAMES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PIXEL_WIDTH-1:0] di_i,
  input  logic                   hs_i,
  input  logic                   vs_i,
  output logic [CNT_W-1:0]       pix_count_o,
  output logic [CNT_W-1:0]       line_count_o,
  output logic [CNT_W-1:0]       hs_count_o,
  output logic [CNT_W-1:0]       vs_count_o,
  output logic [SUM_W-1:0]       frame_sum_o,
  output logic [2:0]             err_o,
  output logic                   meas_valid_o,
  output logic                   locked_o
);

  logic [PIXEL_WIDTH-1:0] di_q;
  logic hs_q, vs_q, hs_dly_q, vs_dly_q;

  state_e           state_q, state_d;
  logic             pub_q, pub_d;
  logic             have_prev_q, have_prev_d;
  logic [CNT_W-1:0] first_pix_q, first_pix_d, first_gap_q, first_gap_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [1:0]       err_q, err_d;

  logic [CNT_W-1:0] pix_count_q, pix_count_d, line_count_q, line_count_d;
  logic [CNT_W-1:0] hs_count_q, hs_count_d, vs_count_q, vs_count_d;
  logic [SUM_W-1:0] frame_sum_q, frame_sum_d;
  logic [2:0]       err_out_q, err_out_d;
  logic             meas_valid_q, meas_valid_d;

  logic [CNT_W-1:0] pix_cnt, line_cnt, gap_cnt, vb_cnt, line_eff;
  logic [3:0]       clean_cnt;
  logic in_sync, in_act, in_vb, act, frame_clr, vs_fall;
  logic hs_rise, line_end, pix_en;
  logic [2:0] pub_err;

  assign in_sync   = (state_q == SYNC);
  assign in_act    = (state_q == ACTIVE);
  assign in_vb     = (state_q == VBLANK);
  // The cycle vs rises already belongs to the blanking interval.
  assign act       = in_act & ~vs_q;
  assign vs_fall   = ~vs_q & vs_dly_q;
  assign hs_rise   = act & hs_q & ~hs_dly_q;
  assign line_end  = in_act & hs_dly_q & (~hs_q | vs_q);
  assign pix_en    = act & hs_q;
  assign frame_clr = in_sync | pub_q;
  assign line_eff  = frame_clr ? '0 : line_cnt;

  sat_cnt #(.W(CNT_W)) u_pix (
    .clk(clk), .rst(rst), .clr_i(frame_clr | hs_rise), .en_i(pix_en), .cnt_o(pix_cnt));
  sat_cnt #(.W(CNT_W)) u_line (
    .clk(clk), .rst(rst), .clr_i(frame_clr), .en_i(hs_rise), .cnt_o(line_cnt));
  sat_cnt #(.W(CNT_W)) u_gap (
    .clk(clk), .rst(rst), .clr_i(frame_clr | hs_rise), .en_i(act & ~hs_q), .cnt_o(gap_cnt));
  sat_cnt #(.W(CNT_W)) u_vb (
    .clk(clk), .rst(rst), .clr_i(in_sync | (in_act & vs_q)),
    .en_i((in_act | in_vb) & vs_q), .cnt_o(vb_cnt));

  always_comb begin
    pub_err           = '0;
    pub_err[ERR_PIX]  = err_q[ERR_PIX];
    pub_err[ERR_HS]   = err_q[ERR_HS];
    pub_err[ERR_GEOM] = have_prev_q &
        ({first_pix_q, line_cnt, first_gap_q, vb_cnt} !=
         {pix_count_q, line_count_q, hs_count_q, vs_count_q});
  end

  sat_cnt #(.W(4)) u_clean (
    .clk(clk), .rst(rst), .clr_i(pub_q & (|pub_err)), .en_i(pub_q & ~(|pub_err)),
    .cnt_o(clean_cnt));

  assign locked_o = (clean_cnt >= 4'(LOCK_FRAMES));

  always_comb begin
    state_d = state_q;
    pub_d   = 1'b0;
    case (state_q)
      SYNC:    if (vs_fall) state_d = ACTIVE;
      ACTIVE:  if (vs_q) state_d = VBLANK;
      VBLANK:  if (vs_fall) begin
        state_d = ACTIVE;
        pub_d   = 1'b1;
      end
      default: state_d = SYNC;
    endcase

    // Line 1 sets the reference length; line 2's rise sets the reference gap.
    first_pix_d = frame_clr ? '0 : first_pix_q;
    if (line_end && line_eff == CNT_W'(1)) first_pix_d = pix_cnt;
    first_gap_d = frame_clr ? '0 : first_gap_q;
    if (hs_rise && line_eff == CNT_W'(1)) first_gap_d = gap_cnt;

    err_d = frame_clr ? '0 : err_q;
    if (line_end && line_eff > CNT_W'(1) && pix_cnt != first_pix_q) err_d[ERR_PIX] = 1'b1;
    if (hs_rise && line_eff > CNT_W'(1) && gap_cnt != first_gap_q) err_d[ERR_HS] = 1'b1;

    sum_d       = (frame_clr ? '0 : sum_q) + (pix_en ? SUM_W'(di_q) : '0);
    have_prev_d = have_prev_q | pub_q;

    pix_count_d  = pix_count_q;
    line_count_d = line_count_q;
    hs_count_d   = hs_count_q;
    vs_count_d   = vs_count_q;
    frame_sum_d  = frame_sum_q;
    err_out_d    = err_out_q;
    meas_valid_d = pub_q;
    if (pub_q) begin
      pix_count_d  = first_pix_q;
      line_count_d = line_cnt;
      hs_count_d   = first_gap_q;
      vs_count_d   = vb_cnt;
      frame_sum_d  = sum_q;
      err_out_d    = pub_err;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      di_q         <= '0;
      hs_q         <= 1'b0;
      vs_q         <= 1'b0;
      hs_dly_q     <= 1'b0;
      vs_dly_q     <= 1'b0;
      state_q      <= SYNC;
      pub_q        <= 1'b0;
      have_prev_q  <= 1'b0;
      first_pix_q  <= '0;
      first_gap_q  <= '0;
      sum_q        <= '0;
      err_q        <= '0;
      pix_count_q  <= '0;
      line_count_q <= '0;
      hs_count_q   <= '0;
      vs_count_q   <= '0;
      frame_sum_q  <= '0;
      err_out_q    <= '0;
      meas_valid_q <= 1'b0;
    end else begin
      di_q         <= di_i;
      hs_q         <= hs_i;
      vs_q         <= vs_i;
      hs_dly_q     <= hs_q;
      vs_dly_q     <= vs_q;
      state_q      <= state_d;
      pub_q        <= pub_d;
      have_prev_q  <= have_prev_d;
      first_pix_q  <= first_pix_d;
      first_gap_q  <= first_gap_d;
      sum_q        <= sum_d;
      err_q        <= err_d;
      pix_count_q  <= pix_count_d;
      line_count_q <= line_count_d;
      hs_count_q   <= hs_count_d;
      vs_count_q   <= vs_count_d;
      frame_sum_q  <= frame_sum_d;
      err_out_q    <= err_out_d;
      meas_valid_q <= meas_valid_d;
    end
  end

  assign pix_count_o  = pix_count_q;
  assign line_count_o = line_count_q;
  assign hs_count_o   = hs_count_q;
  assign vs_count_o   = vs_count_q;
  assign frame_sum_o  = frame_sum_q;
  assign err_o        = err_out_q;
  assign meas_valid_o = meas_valid_q;

endmodule

// File: tb/tb_timing_meas.sv
// tb/tb_timing_meas.sv - randomized frame bench for timing_meas with a frame-level model
module tb_timing_meas;

  logic        clk, rst, hs, vs;
  logic [7:0]  di;
  logic [15:0] pix_count, line_count, hs_count, vs_count;
  logic [31:0] frame_sum;
  logic [2:0]  err;
  logic        meas_valid, locked;

  int errors = 0;
  int checks = 0;

  timing_meas #(.PIXEL_WIDTH(8), .LOCK_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .di_i(di), .hs_i(hs), .vs_i(vs),
    .pix_count_o(pix_count), .line_count_o(line_count), .hs_count_o(hs_count),
    .vs_count_o(vs_count), .frame_sum_o(frame_sum), .err_o(err),
    .meas_valid_o(meas_valid), .locked_o(locked));

  always #5 clk = ~clk;

  // Frame description: gap_q[i] = hs-low cycles before line i, len_q[i] = hs-high cycles.
  int len_q[$];
  int gap_q[$];
  int vb_g, fp_g, di_const_g;
  bit trunc_g;
  int gpix, glines, ggap, gvb;

  // Frame-level reference state
  bit have_prev_m;
  int prev_m[4];
  int clean_m;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic make_frame(input int nl, input int px, input int gp, input int vb);
    len_q.delete();
    gap_q.delete();
    for (int i = 0; i < nl; i++) begin
      len_q.push_back(px);
      gap_q.push_back(gp);
    end
    vb_g = vb;
    fp_g = 2;
    trunc_g = 0;
    di_const_g = -1;
  endtask

  task automatic play_frame(input bit expect_pub, input string name);
    logic [31:0] sum_m;
    logic [2:0]  err_m;
    int n, pulses, seen;
    int exp_m[4];
    bit locked_m;
    sum_m = 0;
    n = len_q.size();
    for (int i = 0; i < n; i++) begin
      hs = 0;
      for (int j = 0; j < gap_q[i]; j++) begin di = 8'($urandom); tick(); end
      for (int j = 0; j < len_q[i]; j++) begin
        di = (di_const_g >= 0) ? 8'(di_const_g) : 8'($urandom);
        hs = 1;
        sum_m += {24'b0, di};
        tick();
      end
      if (i == n - 1 && trunc_g) begin vs = 1; tick(); end
      hs = 0;
    end
    if (!trunc_g) for (int j = 0; j < fp_g; j++) begin di = 8'($urandom); tick(); end
    vs = 1;
    for (int j = 0; j < (trunc_g ? vb_g - 1 : vb_g); j++) tick();
    vs = 0;
    pulses = 0;
    seen = 0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (meas_valid === 1'b1) begin pulses++; seen = k; end
    end
    checks++;
    if (expect_pub && (pulses != 1 || seen != 3)) begin
      errors++;
      $display("FAIL %s_valid: pulses=%0d at tick %0d, required 1 at tick 3", name, pulses, seen);
    end else if (!expect_pub && pulses != 0) begin
      errors++;
      $display("FAIL %s_nopub: pulses=%0d, required 0", name, pulses);
    end
    if (expect_pub) begin
      err_m = 3'b000;
      for (int i = 1; i < n; i++) if (sat16(len_q[i]) != sat16(len_q[0])) err_m[0] = 1'b1;
      for (int i = 2; i < n; i++) if (sat16(gap_q[i]) != sat16(gap_q[1])) err_m[1] = 1'b1;
      exp_m[0] = (n > 0) ? sat16(len_q[0]) : 0;
      exp_m[1] = n;
      exp_m[2] = (n > 1) ? sat16(gap_q[1]) : 0;
      exp_m[3] = sat16(vb_g);
      if (have_prev_m && exp_m != prev_m) err_m[2] = 1'b1;
      prev_m = exp_m;
      have_prev_m = 1;
      clean_m = (err_m == 3'b000) ? ((clean_m < 15) ? clean_m + 1 : 15) : 0;
      locked_m = (clean_m >= 2);
      checks += 7;
      if (pix_count !== 16'(exp_m[0])) begin errors++;
        $display("FAIL %s_pix: got %0d expected %0d", name, pix_count, exp_m[0]); end
      if (line_count !== 16'(exp_m[1])) begin errors++;
        $display("FAIL %s_lines: got %0d expected %0d", name, line_count, exp_m[1]); end
      if (hs_count !== 16'(exp_m[2])) begin errors++;
        $display("FAIL %s_gap: got %0d expected %0d", name, hs_count, exp_m[2]); end
      if (vs_count !== 16'(exp_m[3])) begin errors++;
        $display("FAIL %s_vblank: got %0d expected %0d", name, vs_count, exp_m[3]); end
      if (frame_sum !== sum_m) begin errors++;
        $display("FAIL %s_sum: got %0d expected %0d", name, frame_sum, sum_m); end
      if (err !== err_m) begin errors++;
        $display("FAIL %s_err: got %b expected %b", name, err, err_m); end
      if (locked !== locked_m) begin errors++;
        $display("FAIL %s_locked: got %b expected %b", name, locked, locked_m); end
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) tick();
    checks += 3;
    if ({pix_count, line_count, hs_count, vs_count} !== 64'd0) begin errors++;
      $display("FAIL reset_counts: got %h expected 0", {pix_count, line_count, hs_count, vs_count}); end
    if (frame_sum !== 32'd0 || err !== 3'd0) begin errors++;
      $display("FAIL reset_sum_err: got %h/%b expected 0/000", frame_sum, err); end
    if (meas_valid !== 1'b0 || locked !== 1'b0) begin errors++;
      $display("FAIL reset_flags: got %b%b expected 00", meas_valid, locked); end
    rst = 0;
    tick();
    have_prev_m = 0;
    clean_m = 0;
  endtask

  task automatic test_lock();
    gpix = $urandom_range(8, 40);
    glines = $urandom_range(4, 10);
    ggap = $urandom_range(3, 12);
    gvb = $urandom_range(6, 20);
    make_frame(glines, gpix, ggap, gvb);
    play_frame(0, "lock_sync");
    for (int f = 0; f < 3; f++) play_frame(1, "lock");
  endtask

  task automatic test_sum();
    make_frame(10, 330, 20, 50);
    di_const_g = 128;
    play_frame(1, "sum_const");
    checks++;
    if (frame_sum !== 32'd422400) begin errors++;
      $display("FAIL sum_abs: got %0d expected 422400", frame_sum); end
    make_frame(glines, gpix, ggap, gvb);
    play_frame(1, "sum_back");
  endtask

  task automatic test_bad_pix();
    make_frame(glines, gpix, ggap, gvb);
    play_frame(1, "relock_a");
    play_frame(1, "relock_b");
    len_q[glines / 2] = gpix - 1;
    play_frame(1, "short_line");
    make_frame(glines, gpix, ggap, gvb);
    play_frame(1, "after_bad");
    play_frame(1, "relocked");
  endtask

  task automatic test_lines();
    make_frame(glines + 1, gpix, ggap, gvb);
    play_frame(1, "extra_line");
    make_frame(glines, gpix, ggap, gvb);
    play_frame(1, "lines_back");
  endtask

  task automatic test_gap_trunc();
    make_frame(glines, gpix, ggap, gvb);
    gap_q[3] = ggap + 1;
    play_frame(1, "long_gap");
    make_frame(glines, gpix, ggap, gvb);
    trunc_g = 1;
    len_q[glines - 1] = gpix / 2;
    play_frame(1, "trunc");
    make_frame(glines, gpix, ggap, gvb);
    fp_g = 0;
    play_frame(1, "vs_hs_same");
  endtask

  task automatic test_sat_reset();
    make_frame(1, 65600, 5, 10);
    play_frame(1, "sat");
    hs = 0;
    repeat (5) tick();
    hs = 1;
    repeat (10) tick();
    #3 rst = 1;
    #1;
    checks++;
    if ({pix_count, line_count, hs_count, vs_count, frame_sum, err, meas_valid, locked} !== '0) begin
      errors++;
      $display("FAIL async_reset: got %h expected 0",
               {pix_count, line_count, hs_count, vs_count, frame_sum, err, meas_valid, locked});
    end
    tick();
    rst = 0;
    hs = 0;
    have_prev_m = 0;
    clean_m = 0;
    make_frame(glines, gpix, ggap, gvb);
    play_frame(0, "post_rst_sync");
    play_frame(1, "post_rst");
  endtask

  initial begin
    clk = 0;
    rst = 1;
    hs = 0;
    vs = 0;
    di = 0;
    test_reset();
    test_lock();
    test_sum();
    test_bad_pix();
    test_lines();
    test_gap_trunc();
    test_sat_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timing_meas.md
Name: timing_meas

Overview:
- Receive-side measurement stage that sits directly downstream of the YUV422 test-pattern timing generator.
- Consumes the generator's pixel/hs/vs stream and measures per-frame geometry: active pixels per line, active lines, horizontal blank cycles and vertical blank cycles. It also computes a pixel-data checksum.
- Reports each frame's result, per-frame consistency errors and a lock indication. These are used for link bring-up and for self-check in the video_out bench.

Parameters:
PIXEL_WIDTH, 8, width of di_i.
LOCK_FRAMES, 2, consecutive clean matching frames needed to assert locked_o (range 1..15).

Ports:
clk  input  1  pixel clock.
rst  input  1  asynchronous reset, active-high; clears all state and outputs.
di_i  input  PIXEL_WIDTH  pixel data (interleaved C/Y).
hs_i  input  1  high = active pixel window of a line.
vs_i  input  1  high = vertical blank interval.
pix_count_o  output  16  cycles hs_i high per line.
line_count_o  output  16  hs_i rising edges per frame.
hs_count_o  output  16  hs_i-low cycles between consecutive lines.
vs_count_o  output  16  cycles vs_i high.
frame_sum_o  output  32  sum of di_i while hs_i high, modulo 2^32.
err_o  output  3  per-frame error flags.
meas_valid_o  output  1  one-cycle pulse; all result outputs update on this cycle.
locked_o  output  1  geometry stable.

Behaviour:
- Reset (async, rst=1): every output is 0; FSM goes to SYNC; all counters and history are 0.
- Input stage: di_i, hs_i and vs_i are registered once. Edge detection uses the registered values and their 1-cycle-delayed copies.
- FSM states: SYNC, ACTIVE, VBLANK.
  - SYNC: ignore everything until a falling edge of vs. That edge enters ACTIVE. The partial frame after reset is never published.
  - ACTIVE:
    - hs high: increment line pixel counter; add di to frame sum.
    - hs rising edge: increment line counter.
    - hs low: increment gap counter; the gap counter is cleared at each hs rise.
    - On each hs falling edge, compare the line length with the first line's length; a difference sets err bit0.
    - On each hs rise except the first of the frame, compare the gap with the first measured gap; a difference sets err bit1.
    - vs rising edge enters VBLANK. If hs is high at that moment, the line ends there and its partial length is compared as above.
  - VBLANK: count vs-high cycles; hs activity is ignored. A vs falling edge publishes the frame, resets the per-frame counters and re-enters ACTIVE.
- Publish, on the cycle after the vs falling edge:
  - meas_valid_o=1 for exactly one cycle.
  - Outputs load the first-line pixel length, line count, first gap, vblank count, sum and err.
  - err bit2 is set if {pix, line, hs, vs} differs from the previously published frame. bit2 is never set on the first publish after reset.
  - err_o holds its value until the next publish.
- locked_o:
  - A clean-frame counter increments (saturating) on each publish with err==0; it clears on any publish with err!=0.
  - locked_o=1 while counter ≥ LOCK_FRAMES.
  - It updates on the same cycle as meas_valid_o, so it drops on the publish of a bad frame.
- Width rules:
  - All 16-bit counters saturate at 0xFFFF and never wrap.
  - A saturated value is compared like any other value.
  - frame_sum wraps modulo 2^32; di is zero-extended.
- Simultaneous events: a vs rise and an hs fall in the same cycle are handled as line end followed by VBLANK entry, with no lost compare.
- Latency: meas_valid_o asserts 2 clk edges after the clk edge that first samples vs_i low following high.
- Reset mid-frame: immediate clear, back to SYNC, and no publish of the interrupted frame.

Decomposition:
- Package timing_meas_pkg holds:
  - FSM state encodings SYNC=0, ACTIVE=1, VBLANK=2 (2-bit);
  - ERR_PIX=0, ERR_HS=1, ERR_GEOM=2 bit indices;
  - CNT_W=16, SUM_W=32.
- One sub-module, sat_cnt: a parameterised-width saturating counter with clear and enable inputs. It is instantiated for the pixel, line, gap, vblank and clean-frame counters.

Test Plan:
1. Reset, then 4 frames of 330 pix, 20-cycle gap, 100 lines, 500-cycle vblank -> 3 publishes of 330/100/20/500, err=000; locked_o rises with the 2nd publish.
2. Di_i held at 128 for a 330x100 frame -> frame_sum_o=4,224,000 (0x00407400).
3. Line 50 of a locked frame is 329 pixels -> err=001 and locked_o=0 on that publish. The next frame publishes err=000 with locked_o still 0; the frame after it relocks.
4. A frame with 101 lines after clean frames -> err=100, line_count_o=101, locked_o=0.
5. Gap of 21 on line 7 -> err=010. Vs rise while hs high on line 100 after 200 pixels -> err bit0 set.
6. Line with hs_i high for 70000 cycles -> pix_count_o=0xFFFF. Rst pulse mid-line -> all outputs 0 asynchronously, and no meas_valid_o until one full frame after the next vs fall.
